// File: rtl/demux_2_stream.sv
// 1-to-2 valid/ready sample-stream demultiplexer with per-output one-entry slots.
// The route is captured at the first beat of a burst and held until its last beat.
module demux_2_stream #(
    parameter int m = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [m-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    input  logic         sel,
    output logic [m-1:0] out0_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [m-1:0] out1_data,
    output logic         out1_valid,
    input  logic         out1_ready,
    output logic         route,
    output logic         busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic           r_route;
    logic [m-1:0]   r_data0;
    logic [m-1:0]   r_data1;
    logic           r_valid0;
    logic           r_valid1;

    logic           w_re;
    logic           w_room0;
    logic           w_room1;
    logic           w_accept;
    logic           w_load0;
    logic           w_load1;

    // Inside a burst the locked route wins; sel only matters at a burst start.
    assign w_re     = (r_state == BURST) ? r_route : sel;
    assign w_room0  = !r_valid0 || out0_ready;
    assign w_room1  = !r_valid1 || out1_ready;
    assign in_ready = w_re ? w_room1 : w_room0;
    assign w_accept = in_valid && in_ready;
    assign w_load0  = w_accept && !w_re;
    assign w_load1  = w_accept && w_re;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first means every path drives w_next_state,
    // so no latch is inferred when a case branch leaves it untouched.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept && !in_last) w_next_state = BURST;
            BURST:   if (w_accept && in_last)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_route <= 1'b0;
        end else if (w_accept && (r_state == IDLE)) begin
            r_route <= sel;
        end
    end

    // NOTE: slot data is cleared on reset so outputs read zero afterwards;
    // after a drain the data is deliberately held, only valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data0  <= '0;
            r_valid0 <= 1'b0;
        end else if (w_load0) begin
            r_data0  <= in_data;
            r_valid0 <= 1'b1;
        end else if (r_valid0 && out0_ready) begin
            r_valid0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data1  <= '0;
            r_valid1 <= 1'b0;
        end else if (w_load1) begin
            r_data1  <= in_data;
            r_valid1 <= 1'b1;
        end else if (r_valid1 && out1_ready) begin
            r_valid1 <= 1'b0;
        end
    end

    assign out0_data  = r_data0;
    assign out0_valid = r_valid0;
    assign out1_data  = r_data1;
    assign out1_valid = r_valid1;
    assign route      = r_route;
    assign busy       = (r_state == BURST);

endmodule

// File: tb/tb_demux_2_stream.sv
// Bench for demux_2_stream: directed scenarios plus random traffic, with a
// queue-based scoreboard tracking what each output slot must present.
module tb_demux_2_stream;

    localparam int M = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic [M-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic         sel;
    logic [M-1:0] out0_data;
    logic         out0_valid;
    logic         out0_ready;
    logic [M-1:0] out1_data;
    logic         out1_valid;
    logic         out1_ready;
    logic         route;
    logic         busy;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Scoreboard: each queue holds what the matching slot must be presenting.
    logic [M-1:0] q0[$];
    logic [M-1:0] q1[$];
    logic [M-1:0] d0[$];
    logic [M-1:0] d1[$];
    bit           m_busy  = 1'b0;
    bit           m_route = 1'b0;
    bit           m_re;
    bit           m_rdy;

    demux_2_stream #(.m(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .sel        (sel),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .route      (route),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; this monitor samples 1 time unit
    // before the rising edge and then advances the model across that edge.
    always @(negedge clk) begin
        #4;
        m_re  = m_busy ? m_route : sel;
        m_rdy = m_re ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
        if (mon_en && !rst) begin
            checks++;
            if (in_ready !== m_rdy) begin
                errors++;
                $display("FAIL mon_in_ready: got %b expected %b at %0t", in_ready, m_rdy, $time);
            end
            checks++;
            if (out0_valid !== (q0.size() != 0)) begin
                errors++;
                $display("FAIL mon_out0_valid: got %b expected %b at %0t", out0_valid, q0.size() != 0, $time);
            end
            checks++;
            if (out1_valid !== (q1.size() != 0)) begin
                errors++;
                $display("FAIL mon_out1_valid: got %b expected %b at %0t", out1_valid, q1.size() != 0, $time);
            end
            if (q0.size() != 0) begin
                checks++;
                if (out0_data !== q0[0]) begin
                    errors++;
                    $display("FAIL mon_out0_data: got %h expected %h at %0t", out0_data, q0[0], $time);
                end
            end
            if (q1.size() != 0) begin
                checks++;
                if (out1_data !== q1[0]) begin
                    errors++;
                    $display("FAIL mon_out1_data: got %h expected %h at %0t", out1_data, q1[0], $time);
                end
            end
            checks++;
            if (busy !== m_busy || route !== m_route) begin
                errors++;
                $display("FAIL mon_busy_route: got %b/%b expected %b/%b at %0t", busy, route, m_busy, m_route, $time);
            end
        end
        if (rst) begin
            q0.delete();
            q1.delete();
            m_busy  = 1'b0;
            m_route = 1'b0;
        end else begin
            if (q0.size() != 0 && out0_ready) d0.push_back(q0.pop_front());
            if (q1.size() != 0 && out1_ready) d1.push_back(q1.pop_front());
            if (in_valid && m_rdy) begin
                if (m_re) q1.push_back(in_data);
                else      q0.push_back(in_data);
                if (!m_busy) begin
                    m_route = sel;
                    m_busy  = !in_last;
                end else if (in_last) begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [M-1:0] d, input logic l,
                         input logic s, input logic r0, input logic r1);
        @(negedge clk);
        in_valid   = v;
        in_data    = d;
        in_last    = l;
        sel        = s;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    // Presents one beat until it is taken; returns with time just before the accepting edge.
    task automatic send(input logic [M-1:0] d, input logic l, input logic s,
                        input logic r0, input logic r1, output int waits);
        waits = 0;
        forever begin
            drive(1'b1, d, l, s, r0, r1);
            #4;
            if (in_ready === 1'b1) break;
            waits++;
            if (waits > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: beat %h not accepted after %0d cycles, expected acceptance", d, waits);
                break;
            end
        end
    endtask

    task automatic flush();
        repeat (3) drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        d0.delete();
        d1.delete();
    endtask

    task automatic test_reset();
        #4;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_data !== '0 || out1_data !== '0) begin
            errors++;
            $display("FAIL reset_slots: got v=%b%b d0=%h d1=%h expected v=00 d0=000 d1=000",
                     out0_valid, out1_valid, out0_data, out1_data);
        end
        checks++;
        if (busy !== 1'b0 || route !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b route=%b in_ready=%b expected 0 0 1", busy, route, in_ready);
        end
    endtask

    task automatic test_burst_out0();
        int w;
        d0.delete();
        d1.delete();
        for (int i = 0; i < 4; i++) begin
            send(M'(i + 1), i == 3, 1'b0, 1'b1, 1'b0, w);
            checks++;
            if (busy !== (i != 0)) begin
                errors++;
                $display("FAIL burst0_busy: beat %0d got %b expected %b", i, busy, i != 0);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        #4;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL burst0_busy_end: got %b expected 0", busy);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (d0.size() != 4 || d1.size() != 0) begin
            errors++;
            $display("FAIL burst0_count: got out0=%0d out1=%0d expected 4 0", d0.size(), d1.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (d0[i] !== M'(i + 1)) begin
                    errors++;
                    $display("FAIL burst0_data: beat %0d got %h expected %h", i, d0[i], M'(i + 1));
                end
            end
        end
    endtask

    task automatic test_route_lock();
        int w;
        flush();
        send(12'hA00, 1'b0, 1'b1, 1'b1, 1'b1, w);
        send(12'hA01, 1'b0, 1'b1, 1'b1, 1'b1, w);
        send(12'hA02, 1'b1, 1'b0, 1'b1, 1'b1, w);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        #4;
        checks++;
        if (route !== 1'b1) begin
            errors++;
            $display("FAIL lock_route: got %b expected 1", route);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (d1.size() != 3 || d0.size() != 0 || d1[0] !== 12'hA00 || d1[1] !== 12'hA01 || d1[2] !== 12'hA02) begin
            errors++;
            $display("FAIL lock_data: got out1 count %0d out0 count %0d expected A00..A02 on out1 only",
                     d1.size(), d0.size());
        end
    endtask

    task automatic test_backpressure();
        int w;
        flush();
        send(12'h123, 1'b1, 1'b0, 1'b0, 1'b1, w);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 12'h456, 1'b1, 1'b0, 1'b0, 1'b1);
            #4;
            checks++;
            if (in_ready !== 1'b0 || out0_valid !== 1'b1 || out0_data !== 12'h123) begin
                errors++;
                $display("FAIL bp_hold: got rdy=%b v=%b d=%h expected 0 1 123", in_ready, out0_valid, out0_data);
            end
        end
        drive(1'b1, 12'h456, 1'b1, 1'b0, 1'b1, 1'b1);
        #4;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_refill_ready: got %b expected 1", in_ready);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        #4;
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 12'h456 || d0.size() != 1 || d0[0] !== 12'h123) begin
            errors++;
            $display("FAIL bp_refill: got v=%b d=%h drained=%0d expected 1 456 1", out0_valid, out0_data, d0.size());
        end
    endtask

    task automatic test_independence();
        int w;
        flush();
        send(12'h7FF, 1'b1, 1'b1, 1'b1, 1'b0, w);
        send(12'h055, 1'b1, 1'b0, 1'b0, 1'b0, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL indep_wait: got %0d stall cycles expected 0", w);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 12'h055 || out1_valid !== 1'b1 || out1_data !== 12'h7FF) begin
            errors++;
            $display("FAIL indep_hold: got out0 %b/%h out1 %b/%h expected 1/055 1/7ff",
                     out0_valid, out0_data, out1_valid, out1_data);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        flush();
        for (int i = 0; i < 4; i++) begin
            send(M'(12'h10 + i), 1'b1, i[0], 1'b1, 1'b1, w);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_busy: beat %0d got %b expected 0", i, busy);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (d0.size() != 2 || d1.size() != 2 || d0[0] !== 12'h10 || d0[1] !== 12'h12 ||
            d1[0] !== 12'h11 || d1[1] !== 12'h13) begin
            errors++;
            $display("FAIL b2b_data: got counts %0d/%0d expected 10,12 on out0 and 11,13 on out1",
                     d0.size(), d1.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        int w;
        flush();
        send(12'hB00, 1'b0, 1'b1, 1'b1, 1'b1, w);
        send(12'hB01, 1'b0, 1'b1, 1'b1, 1'b1, w);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        checks++;
        if (busy !== 1'b1 || route !== 1'b1 || out1_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got busy=%b route=%b v1=%b expected 1 1 1", busy, route, out1_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #4;
        checks++;
        if (out1_valid !== 1'b0 || busy !== 1'b0 || route !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_post: got v1=%b busy=%b route=%b rdy=%b expected 0 0 0 1",
                     out1_valid, busy, route, in_ready);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(9, 0) < 7, M'($urandom), $urandom_range(3, 0) == 0,
                  1'($urandom), $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7);
        end
        flush();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        #4;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: got v=%b%b expected both slots empty", out0_valid, out1_valid);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        sel        = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        test_reset();
        test_burst_out0();
        test_route_lock();
        test_backpressure();
        test_independence();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_2_stream.md
Name: demux_2_stream

Overview:
Parameterized 1-to-2 sample-stream demultiplexer with valid/ready handshakes on every side. It is the steering counterpart of the 2-input select mux. It routes bursts of m-bit samples from one producer (e.g. the DDS phase/waveform pipeline) to one of two consumers (e.g. two DAC/output channels). Each output has a one-entry registered slot, and the route is locked for the duration of a burst so a select change can never split a burst across outputs.

Parameters:
m, 12, width of data path in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_data  input  m  input sample
in_valid  input  1  producer has a sample on in_data
in_ready  output  1  block accepts in_data this cycle (combinational)
in_last  input  1  current input beat is the final beat of a burst
sel  input  1  requested route: 0 = out0, 1 = out1; honoured only at burst start
out0_data  output  m  output 0 sample (registered)
out0_valid  output  1  output 0 slot full
out0_ready  input  1  consumer 0 takes out0_data this cycle
out1_data  output  m  output 1 sample (registered)
out1_valid  output  1  output 1 slot full
out1_ready  input  1  consumer 1 takes out1_data this cycle
route  output  1  currently locked route (registered)
busy  output  1  high while a multi-beat burst is in progress

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst high at a clock edge):
  - out0_valid = out1_valid = 0.
  - out0_data = out1_data = 0.
  - route = 0, busy = 0, state = IDLE.
  - Any partially routed burst is discarded. Slot contents are dropped, not delivered.
- FSM states:
  - IDLE: no burst open.
  - BURST: a burst is open and the route is locked.
- Effective route: re = sel in IDLE, re = route in BURST. A sel change during BURST has no effect.
- in_ready = !slot[re].valid || outN_ready[re], where N = re. The full slot may be refilled in the same cycle it drains. in_ready never depends on the non-selected slot.
- Accept = in_valid && in_ready.
- On accept:
  - slot[re].data <= in_data and slot[re].valid <= 1, visible on the next cycle.
  - Latency from accept to outN_valid is exactly 1 cycle.
- Transitions:
  - IDLE, accept, !in_last -> BURST; route <= sel.
  - IDLE, accept, in_last -> IDLE. Single-beat burst; route <= sel.
  - BURST, accept, in_last -> IDLE. route holds its value.
  - BURST, accept, !in_last -> BURST.
  - No accept -> state and route unchanged.
- busy = (state == BURST).
- Slot drain:
  - outN_valid && outN_ready with no same-cycle refill -> outN_valid <= 0.
  - Data is held (not cleared) after drain.
  - Drain with same-cycle refill keeps outN_valid = 1 and loads the new data.
- Slots are independent. The non-routed slot keeps draining while the other is being filled.
- outN_data and outN_valid are stable while outN_valid && !outN_ready (standard hold rule).
- Throughput: 1 beat/cycle sustained when the selected consumer holds ready high.
- in_valid low: no state change regardless of sel or in_last.
- in_last is sampled only on accepted beats.
- No data is ever duplicated to both outputs or lost, except on reset.

Test Plan:
1. Reset, then sel=0 and 4-beat burst 0x001..0x004 with in_last on 0x004, out0_ready=1 -> out0 shows 0x001..0x004 on cycles 1..4 after each accept; out1_valid stays 0; busy high from cycle after first accept until cycle after the last accept.
2. Burst on sel=1 with sel toggled to 0 after the 2nd beat, 3 beats 0xA00..0xA02 -> all three beats appear on out1; route stays 1; out0_valid stays 0.
3. Backpressure: route 0, out0_ready=0, send 0x123 then present 0x456 -> in_ready drops after the first accept; 0x123 is held on out0; raising out0_ready for 1 cycle drains 0x123 and accepts 0x456 in that same cycle.
4. Independence: out1 holds 0x7FF unread (out1_ready=0); send single-beat 0x055 with sel=0 -> accepted immediately; out0 presents 0x055; out1 still holds 0x7FF.
5. Single-beat bursts alternating sel 0,1,0,1 with in_last=1, data 0x10..0x13 -> 0x10 and 0x12 on out0, 0x11 and 0x13 on out1; busy never asserts.
6. Reset mid-burst: 2 beats of a route-1 burst accepted, out1_ready=0, then rst pulsed for 1 cycle -> out1_valid=0, busy=0, route=0, in_ready=1 on the cycle after reset.
